// File: rtl/iter_divider.sv
// iter_divider: multi-cycle signed/unsigned integer divider.
// Non-restoring division on operand magnitudes, UNROLL quotient bits per clock,
// start/busy/done handshake, one-cycle fast path for divide-by-zero and
// signed overflow, synchronous flush.
module iter_divider #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned STEPS = WIDTH / UNROLL;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     pr_q, pr_d;       // signed partial remainder
    logic [WIDTH-1:0]   acc_q, acc_d;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dvs_q, dvs_d;     // |divisor|
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               spec_q, spec_d;   // special-case result pending
    logic               sdbz_q, sdbz_d;   // pending special is divide-by-zero
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     pr_step;
    logic [WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]   rem_fix;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign result      = {rem_q, quo_q};

    // Operand signs and magnitudes at accept time.
    assign a_neg = signed_mode & dividend[WIDTH-1];
    assign b_neg = signed_mode & divisor[WIDTH-1];
    assign a_mag = a_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign b_mag = b_neg ? (~divisor + WIDTH'(1)) : divisor;

    // Final remainder correction: a negative partial remainder gets |divisor| added back.
    assign rem_fix = pr_q[WIDTH] ? (pr_q[WIDTH-1:0] + dvs_q) : pr_q[WIDTH-1:0];

    // UNROLL chained non-restoring steps.
    always_comb begin
        logic [WIDTH:0]   pr_v;
        logic [WIDTH-1:0] acc_v;
        logic [WIDTH:0]   sh_v;
        pr_v  = pr_q;
        acc_v = acc_q;
        sh_v  = '0;
        for (int i = 0; i < int'(UNROLL); i++) begin
            sh_v = {pr_v[WIDTH-1:0], acc_v[WIDTH-1]};
            if (!pr_v[WIDTH]) begin
                pr_v = sh_v - {1'b0, dvs_q};
            end else begin
                pr_v = sh_v + {1'b0, dvs_q};
            end
            acc_v = {acc_v[WIDTH-2:0], ~pr_v[WIDTH]};
        end
        pr_step  = pr_v;
        acc_step = acc_v;
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        spec_d  = 1'b0;
        sdbz_d  = sdbz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        if (flush) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Publish a special-case result captured on the previous edge.
                    if (spec_q) begin
                        quo_d  = sdbz_q ? '1 : acc_q;
                        rem_d  = sdbz_q ? acc_q : '0;
                        dbz_d  = sdbz_q;
                        done_d = 1'b1;
                    end
                    if (start) begin
                        qneg_d = a_neg ^ b_neg;
                        rneg_d = a_neg;
                        dvs_d  = b_mag;
                        pr_d   = '0;
                        cnt_d  = CNT_W'(STEPS - 1);
                        if (divisor == '0) begin
                            spec_d = 1'b1;
                            sdbz_d = 1'b1;
                            acc_d  = dividend;
                        end else if (signed_mode && dividend == MIN_NEG && divisor == '1) begin
                            spec_d = 1'b1;
                            sdbz_d = 1'b0;
                            acc_d  = dividend;
                        end else begin
                            acc_d   = a_mag;
                            state_d = ITER;
                            busy_d  = 1'b1;
                        end
                    end
                end
                ITER: begin
                    pr_d  = pr_step;
                    acc_d = acc_step;
                    if (cnt_q == CNT_W'(0)) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    quo_d   = qneg_q ? (~acc_q + WIDTH'(1)) : acc_q;
                    rem_d   = rneg_q ? (~rem_fix + WIDTH'(1)) : rem_fix;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            spec_q  <= 1'b0;
            sdbz_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            spec_q  <= spec_d;
            sdbz_q  <= sdbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed and randomized checks of iter_divider at
// WIDTH=32/UNROLL=1 and WIDTH=16/UNROLL=4 against a transaction-level model.
module tb_iter_divider;

    typedef longint unsigned u64;
    typedef longint          s64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s32, sm32, f32;
    logic [31:0] a32, b32;
    logic        busy32, done32, dbz32;
    logic [31:0] q32, r32;
    logic [63:0] res32;

    logic        s16, sm16, f16;
    logic [15:0] a16, b16;
    logic        busy16, done16, dbz16;
    logic [15:0] q16, r16;
    logic [31:0] res16;

    iter_divider #(.WIDTH(32), .UNROLL(1)) u_div32 (
        .clk(clk), .rst_n(rst_n), .start(s32), .signed_mode(sm32), .flush(f32),
        .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_by_zero(dbz32), .result(res32)
    );

    iter_divider #(.WIDTH(16), .UNROLL(4)) u_div16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .signed_mode(sm16), .flush(f16),
        .dividend(a16), .divisor(b16), .busy(busy16), .done(done16),
        .quotient(q16), .remainder(r16), .div_by_zero(dbz16), .result(res16)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state per instance (0: 32-bit, 1: 16-bit): cycles to done, pending and held results.
    bit m_busy [2];
    bit m_done [2];
    int m_cd   [2];
    u64 m_q    [2];
    u64 m_r    [2];
    bit m_z    [2];
    u64 p_q    [2];
    u64 p_r    [2];
    bit p_z    [2];

    // Reference division by plain arithmetic: truncating quotient, remainder signed like dividend.
    function automatic void ref_div(input u64 a, input u64 b, input bit sm, input int w,
                                    output u64 q, output u64 r, output bit z);
        u64 mask;
        s64 sa, sb;
        mask = (u64'(1) << w) - 1;
        z = 1'b0;
        if (b == 0) begin
            q = mask; r = a; z = 1'b1;
        end else if (!sm) begin
            q = a / b; r = a % b;
        end else begin
            sa = s64'(a);
            sb = s64'(b);
            if (((a >> (w - 1)) & 1) != 0) sa = sa - (s64'(1) <<< w);
            if (((b >> (w - 1)) & 1) != 0) sb = sb - (s64'(1) <<< w);
            q = u64'(sa / sb) & mask;
            r = u64'(sa % sb) & mask;
        end
    endfunction

    function automatic bit is_special(input u64 a, input u64 b, input bit sm, input int w);
        u64 mask;
        mask = (u64'(1) << w) - 1;
        return (b == 0) || (sm && a == (u64'(1) << (w - 1)) && b == mask);
    endfunction

    // Advance the model by one rising edge.
    task automatic model_edge(input int i, input bit st, input bit sm, input bit fl,
                              input u64 a, input u64 b);
        int w, n;
        bit acc;
        w = (i == 0) ? 32 : 16;
        n = (i == 0) ? 32 : 4;
        if (!rst_n) begin
            m_busy[i] = 0; m_done[i] = 0; m_cd[i] = 0;
            m_q[i] = 0; m_r[i] = 0; m_z[i] = 0;
            return;
        end
        m_done[i] = 0;
        if (fl) begin
            m_busy[i] = 0; m_cd[i] = 0;
            return;
        end
        acc = st && !m_busy[i];
        if (m_cd[i] > 0) begin
            m_cd[i]--;
            if (m_cd[i] == 0) begin
                m_done[i] = 1;
                m_busy[i] = 0;
                m_q[i] = p_q[i]; m_r[i] = p_r[i]; m_z[i] = p_z[i];
            end
        end
        if (acc) begin
            ref_div(a, b, sm, w, p_q[i], p_r[i], p_z[i]);
            if (is_special(a, b, sm, w)) begin
                m_cd[i] = 1;
            end else begin
                m_cd[i]   = n + 1;
                m_busy[i] = 1;
            end
        end
    endtask

    task automatic compare(input int i, input logic bz, input logic dn, input logic [63:0] q,
                           input logic [63:0] r, input logic z, input logic [63:0] res);
        int w;
        u64 er;
        w  = (i == 0) ? 32 : 16;
        er = (m_r[i] << w) | m_q[i];
        checks++;
        if (bz !== m_busy[i] || dn !== m_done[i] || q !== m_q[i] || r !== m_r[i] ||
            z !== m_z[i] || res !== er) begin
            failures++;
            $display("FAIL cmp cycle=%0d dut%0d actual: busy=%b done=%b q=%h r=%h dbz=%b res=%h required: busy=%b done=%b q=%h r=%h dbz=%b res=%h",
                     cyc, w, bz, dn, q, r, z, res, m_busy[i], m_done[i], m_q[i], m_r[i], m_z[i], er);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: model update at the rising edge, comparison at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge(0, s32, sm32, f32, u64'(a32), u64'(b32));
        model_edge(1, s16, sm16, f16, u64'(a16), u64'(b16));
        @(negedge clk);
        cyc++;
        compare(0, busy32, done32, 64'(q32), 64'(r32), dbz32, res32);
        compare(1, busy16, done16, 64'(q16), 64'(r16), dbz16, 64'(res16));
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                        input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                        input logic ez, input string tag);
        int lat;
        s32 = 1'b1; a32 = a; b32 = b; sm32 = sm;
        cycle();
        s32 = 1'b0;
        lat = 0;
        while (done32 !== 1'b1 && lat < 200) begin
            cycle();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_q"}, 64'(q32), 64'(eq));
        chk({tag, "_r"}, 64'(r32), 64'(er));
        chk({tag, "_dbz"}, 64'(dbz32), 64'(ez));
    endtask

    initial begin
        u64 tq, tr;
        bit tz;
        int lat, nd, n_ops, load_cyc, d0_cyc, d1_cyc, rsel;

        rst_n = 1'b0;
        s32 = 0; sm32 = 0; f32 = 0; a32 = '0; b32 = '0;
        s16 = 0; sm16 = 0; f16 = 0; a16 = '0; b16 = '0;
        repeat (3) cycle();
        chk("rst_busy", 64'(busy32), 64'(0));
        chk("rst_done", 64'(done32), 64'(0));
        chk("rst_q", 64'(q32), 64'(0));
        chk("rst_r", 64'(r32), 64'(0));
        rst_n = 1'b1;
        cycle();

        // Model pinned to hand-computed values.
        ref_div(u64'(32'hFFFFFFF9), u64'(2), 1'b1, 32, tq, tr, tz);
        chk("model_m7d2_q", 64'(tq), 64'h0000_0000_FFFF_FFFD);
        chk("model_m7d2_r", 64'(tr), 64'h0000_0000_FFFF_FFFF);
        ref_div(u64'(16'h8000), u64'(16'hFFFF), 1'b1, 16, tq, tr, tz);
        chk("model_ovf16_q", 64'(tq), 64'h8000);
        ref_div(u64'(100), u64'(0), 1'b0, 16, tq, tr, tz);
        chk("model_dbz16_q", 64'(tq), 64'hFFFF);
        chk("model_dbz16_z", 64'(tz), 64'(1));

        // Directed 32-bit vectors.
        op32(32'hFFFFFFF9, 32'h00000002, 1'b1, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "s_m7_2");
        op32(32'h00000007, 32'hFFFFFFFE, 1'b1, 33, 32'hFFFFFFFD, 32'h00000001, 1'b0, "s_7_m2");
        op32(32'hFFFFFFF9, 32'h00000002, 1'b0, 33, 32'h7FFFFFFC, 32'h00000001, 1'b0, "u_big_2");
        op32(32'h12345678, 32'h00000000, 1'b0, 1,  32'hFFFFFFFF, 32'h12345678, 1'b1, "dbz");
        op32(32'h80000000, 32'hFFFFFFFF, 1'b1, 1,  32'h80000000, 32'h00000000, 1'b0, "ovf");

        // Flush during ITER, then a fresh start in the next cycle.
        s32 = 1'b1; a32 = 32'd100; b32 = 32'd7; sm32 = 1'b0;
        cycle();
        s32 = 1'b0;
        repeat (9) cycle();
        f32 = 1'b1;
        cycle();
        f32 = 1'b0;
        chk("flush_busy", 64'(busy32), 64'(0));
        chk("flush_hold_q", 64'(q32), 64'h8000_0000);
        op32(32'hFFFFFF9C, 32'h00000007, 1'b1, 33, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, "post_flush");

        // start together with flush is dropped.
        s32 = 1'b1; f32 = 1'b1; a32 = 32'd9; b32 = 32'd3;
        cycle();
        s32 = 1'b0; f32 = 1'b0;
        chk("start_flush_busy", 64'(busy32), 64'(0));
        repeat (3) cycle();

        // start held: junk operands mid-ITER ignored, next op accepted in the done cycle.
        s32 = 1'b1; sm32 = 1'b1; a32 = 32'd1000; b32 = 32'hFFFFFFF6;
        cycle();
        a32 = 32'hDEADBEEF; b32 = 32'd3; sm32 = 1'b0;
        lat = 0;
        while (done32 !== 1'b1 && lat < 200) begin cycle(); lat++; end
        chk("held_lat", 64'(lat), 64'(33));
        chk("held_q", 64'(q32), 64'hFFFF_FF9C);
        chk("held_r", 64'(r32), 64'(0));
        a32 = 32'd12345; b32 = 32'd100; sm32 = 1'b0;
        cycle();
        s32 = 1'b0;
        chk("b2b_busy", 64'(busy32), 64'(1));
        lat = 0;
        while (done32 !== 1'b1 && lat < 200) begin cycle(); lat++; end
        chk("b2b_lat", 64'(lat), 64'(33));
        chk("b2b_q", 64'(q32), 64'(123));
        chk("b2b_r", 64'(r32), 64'(45));

        // Reset mid-ITER clears outputs at once and no done follows.
        s32 = 1'b1; a32 = 32'd50; b32 = 32'd3; sm32 = 1'b0;
        cycle();
        s32 = 1'b0;
        repeat (10) cycle();
        rst_n = 1'b0;
        #1;
        chk("arst_q", 64'(q32), 64'(0));
        chk("arst_r", 64'(r32), 64'(0));
        chk("arst_busy", 64'(busy32), 64'(0));
        repeat (2) cycle();
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            cycle();
            if (done32 === 1'b1) nd++;
        end
        chk("arst_no_done", 64'(nd), 64'(0));

        // 16-bit UNROLL=4: back-to-back stream with start held high.
        n_ops = 0; nd = 0; load_cyc = 0; d0_cyc = 0; d1_cyc = 0;
        s16 = 1'b1;
        for (int c = 0; c < 20000 && n_ops < 1000; c++) begin
            if (!m_busy[1]) begin
                if (n_ops == 0) begin
                    a16 = 16'd1000; b16 = 16'd7; sm16 = 1'b0; load_cyc = cyc;
                end else if (n_ops == 1) begin
                    a16 = 16'hFC18; b16 = 16'd7; sm16 = 1'b1;
                end else begin
                    rsel = int'($urandom_range(0, 7));
                    a16  = 16'($urandom);
                    sm16 = 1'($urandom_range(0, 1));
                    case (rsel)
                        0:       b16 = 16'h0000;
                        1: begin b16 = 16'hFFFF; if ($urandom_range(0, 1) == 1) a16 = 16'h8000; end
                        2:       b16 = 16'($urandom_range(1, 15));
                        default: b16 = 16'($urandom);
                    endcase
                end
                n_ops++;
            end
            cycle();
            if (done16 === 1'b1) begin
                if (nd == 0) begin
                    d0_cyc = cyc;
                    chk("r16_first_q", 64'(q16), 64'(142));
                    chk("r16_first_r", 64'(r16), 64'(6));
                end else if (nd == 1) begin
                    d1_cyc = cyc;
                    chk("r16_second_q", 64'(q16), 64'hFF72);
                    chk("r16_second_r", 64'(r16), 64'hFFFA);
                end
                nd++;
            end
        end
        s16 = 1'b0;
        repeat (10) begin
            cycle();
            if (done16 === 1'b1) nd++;
        end
        chk("r16_latency", 64'(d0_cyc - (load_cyc + 1)), 64'(5));
        chk("r16_issue_gap", 64'(d1_cyc - d0_cyc), 64'(6));
        chk("r16_done_count", 64'(nd), 64'(1000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
# iter_divider

Multi-cycle signed/unsigned integer divider for the EX stage, the parametrised successor to the single-cycle combinational array divider. It runs non-restoring division on operand magnitudes, UNROLL quotient bits per clock. A start/busy/done handshake lets the pipeline stall on long divides. Divide-by-zero and signed overflow are special-cased and return in one cycle.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of UNROLL, and at least 4.
- UNROLL, 1, quotient bits resolved per ITER cycle; legal values are 1, 2 and 4.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a divide; sampled only when busy=0.
- signed_mode  input  1  1 = two's-complement divide, 0 = unsigned; captured with start.
- flush  input  1  synchronous abort of any in-flight divide.
- dividend  input  WIDTH  captured on an accepted start.
- divisor  input  WIDTH  captured on an accepted start.
- busy  output  1  high while a divide is in flight (ITER or FIX).
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag, valid with done.
- result  output  2*WIDTH  {remainder, quotient}.

## Operation
- States:
  - IDLE: waiting for start.
  - ITER: WIDTH/UNROLL cycles of non-restoring steps.
  - FIX: one cycle of remainder correction and sign application.
- Accept: start=1 and busy=0 and flush=0 at an edge. The block captures signed_mode, the sign bits, |dividend|, |divisor| and the raw dividend.
  - Magnitudes are taken only when signed_mode=1 and the sign bit is set.
  - The special-case checks run in the same cycle.
- Special cases, evaluated at accept. Each one registers its result and pulses done on the next edge, then the block returns to IDLE.
  - divisor=0: quotient = all ones, remainder = dividend, div_by_zero=1.
  - signed_mode=1, dividend=100…0, divisor = all ones: quotient = dividend, remainder=0, div_by_zero=0.
- ITER:
  - The partial remainder is WIDTH+1 bits wide and signed.
  - Each step shifts in the next dividend magnitude bit. It subtracts |divisor| if the partial remainder is ≥0 and adds |divisor| otherwise.
  - The quotient bit is the inverted sign of the new partial remainder.
  - UNROLL steps are chained combinationally per cycle. A step counter counts down from WIDTH/UNROLL-1, and the block moves to FIX when it reaches 0.
- FIX:
  - If the partial remainder is negative, add |divisor|.
  - Quotient is negated if signed_mode and the operand signs differ.
  - Remainder is negated if signed_mode and the dividend is negative.
  - Quotient truncates toward zero, and the remainder takes the sign of the dividend.
  - FIX registers the outputs, pulses done, and the block goes to IDLE.
- Output hold: quotient, remainder and div_by_zero hold their values until the next done. A flush does not change them.
- flush:
  - In any state, flush returns the block to IDLE at the next edge with busy=0 and no done.
  - If start and flush are high together, flush wins and the start is dropped.
- start while busy=1 is ignored. It is not queued.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Let edge k be the accept edge. Normal latency:
  - ITER occupies edges k+1 … k+WIDTH/UNROLL.
  - FIX happens at edge k+WIDTH/UNROLL+1, and done is high for the cycle after it.
  - WIDTH=32, UNROLL=1: done 33 cycles after accept. UNROLL=4: 9 cycles.
- Special-case latency: done is high for the cycle after edge k+1; busy stays 0 throughout.
- busy goes high on edge k (normal case only) and falls on the same edge that raises done.
- Back-to-back: start may be asserted in the done cycle. It is accepted there because busy=0, so the zero-bubble issue rate is one divide per WIDTH/UNROLL+2 cycles.
- Reset mid-operation: outputs clear immediately, and no done pulse is issued afterwards.

## Test plan
- Reset, then WIDTH=32, UNROLL=1, signed, 0xFFFFFFF9 / 0x00000002 (−7/2) → done at cycle 33, quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1).
- Signed 0x00000007 / 0xFFFFFFFE (7/−2) → quotient=0xFFFFFFFD (−3), remainder=0x00000001. Unsigned 0xFFFFFFF9 / 0x00000002 → quotient=0x7FFFFFFC, remainder=0x00000001.
- Divisor=0 with dividend=0x12345678 → done one cycle after accept, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, div_by_zero=0.
- flush at ITER cycle 10, then a new start in the next cycle → no done for the first op; the second op completes at full latency with correct results; outputs hold the previous values until then.
- start held high across a full op with new operands presented in the done cycle → the second op is accepted in the done cycle; a start pulse mid-ITER is ignored; rst_n dropped mid-ITER clears all outputs with no spurious done.
- UNROLL=4 and WIDTH=16: 1,000 random signed and unsigned pairs against a reference model → all results match, with done exactly 5 cycles after each accept (6 cycles accept-to-accept back-to-back).
